hazard_ctrl: RTL

- Pipeline sequencing controller for the execute-stage ALU in the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Tracks the instructions in the EX, MEM and WB slots (valid, rd, opcode class).
- Decides per cycle: ALU operand forwarding selects, load-use bubbles, branch/jump redirect flushes, and data-memory wait freezes.
- Sits beside the ID/EX register; its outputs gate the PC, the IF/ID register and the ALU operand muxes.

---
 rtl/hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EX-stage sequencing controller for the 5-stage RV32I pipe.
// Tracks EX/MEM/WB slots and produces stall, flush, redirect and ALU
// operand-forwarding controls.
// Optional feature macro HAZARD_FWD_EN: when defined, operand forwarding with
// single-bubble load-use stalls; when undefined, every RAW hazard against
// EX/MEM stalls until it clears and forwarding selects stay 00.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       ex_branch,
  input  logic       dmem_ready,
  output logic       pc_stall,
  output logic       id_stall,
  output logic       id_flush,
  output logic       redirect,
  output logic       ex_valid,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    CL_NONE, CL_R, CL_STORE, CL_BRANCH, CL_I,
    CL_LOAD, CL_JALR, CL_JAL, CL_LUI, CL_AUIPC
  } cls_t;

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, FAULT} state_t;

  localparam logic [7:0] TMO = MEM_TIMEOUT[7:0];

  function automatic cls_t decode(input logic [6:0] op);
    cls_t c;
    case (op)
      7'b0110011: c = CL_R;
      7'b0100011: c = CL_STORE;
      7'b1100011: c = CL_BRANCH;
      7'b0010011: c = CL_I;
      7'b0000011: c = CL_LOAD;
      7'b1100111: c = CL_JALR;
      7'b1101111: c = CL_JAL;
      7'b0110111: c = CL_LUI;
      7'b0010111: c = CL_AUIPC;
      default:    c = CL_NONE;
    endcase
    return c;
  endfunction

  function automatic logic uses_rs1(input cls_t c);
    return c inside {CL_R, CL_STORE, CL_BRANCH, CL_I, CL_LOAD, CL_JALR};
  endfunction

  function automatic logic uses_rs2(input cls_t c);
    return c inside {CL_R, CL_STORE, CL_BRANCH};
  endfunction

  function automatic logic writes_rd(input cls_t c);
    return !(c inside {CL_NONE, CL_STORE, CL_BRANCH});
  endfunction

  // Producer slot (v, c, rd) feeds a source operand of consumer class src.
  function automatic logic raw_hit(input logic v, input cls_t c,
                                   input logic [4:0] rd, input cls_t src,
                                   input logic [4:0] rs1, input logic [4:0] rs2);
    return v && writes_rd(c) && (rd != '0) &&
           ((uses_rs1(src) && (rs1 == rd)) || (uses_rs2(src) && (rs2 == rd)));
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic       ex_v, mem_v;
  logic [4:0] ex_rd, mem_rd;
  cls_t       ex_cls, mem_cls;

  cls_t       id_cls;
  logic       mem_busy;
  logic       take_redirect;
  logic       hazard;
  logic       advance;
  logic       bubble;
  logic       clear;

  // ID decode and per-cycle hazard conditions
  always_comb begin
    id_cls        = decode(id_opcode);
    mem_busy      = mem_v && (mem_cls inside {CL_LOAD, CL_STORE}) && !dmem_ready;
    take_redirect = ex_v && (((ex_cls == CL_BRANCH) && ex_branch) ||
                             (ex_cls == CL_JAL) || (ex_cls == CL_JALR));
  end

`ifdef HAZARD_FWD_EN
  logic [4:0] ex_rs1, ex_rs2;
  logic       wb_v;
  logic [4:0] wb_rd;
  cls_t       wb_cls;

  function automatic logic [1:0] fwd_pick(input logic [4:0] rs);
    logic [1:0] s;
    s = 2'b00;
    if (mem_v && writes_rd(mem_cls) && (mem_rd != '0) && (mem_rd == rs))
      s = 2'b01;
    else if (wb_v && writes_rd(wb_cls) && (wb_rd != '0) && (wb_rd == rs))
      s = 2'b10;
    return s;
  endfunction

  // Load-use: only an EX load can stall an ID consumer
  always_comb begin
    hazard = id_valid && (ex_cls == CL_LOAD) &&
             raw_hit(ex_v, ex_cls, ex_rd, id_cls, id_rs1, id_rs2);
  end

  // Operand source selects for the instruction currently in EX
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (ex_v) begin
      fwd_a_sel = fwd_pick(ex_rs1);
      fwd_b_sel = fwd_pick(ex_rs2);
    end
  end

  // Source fields and WB slot, needed only for forwarding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      wb_v   <= 1'b0;
      wb_rd  <= '0;
      wb_cls <= CL_NONE;
    end else if (clear) begin
      wb_v   <= 1'b0;
    end else if (advance) begin
      ex_rs1 <= id_rs1;
      ex_rs2 <= id_rs2;
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      wb_cls <= mem_cls;
    end
  end
`else
  // Without forwarding any pending RAW against EX or MEM stalls ID
  always_comb begin
    hazard = id_valid &&
             (raw_hit(ex_v, ex_cls, ex_rd, id_cls, id_rs1, id_rs2) ||
              raw_hit(mem_v, mem_cls, mem_rd, id_cls, id_rs1, id_rs2));
  end

  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;
`endif

  // Next state, wait counter and pipeline control outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    advance     = 1'b0;
    bubble      = 1'b0;
    clear       = 1'b0;
    pc_stall    = 1'b0;
    id_stall    = 1'b0;
    id_flush    = 1'b0;
    redirect    = 1'b0;
    mem_timeout = 1'b0;
    case (state_q)
      FAULT: begin
        mem_timeout = 1'b1;
        pc_stall    = 1'b1;
        id_stall    = 1'b1;
      end
      default: begin
        if (mem_busy) begin
          pc_stall = 1'b1;
          id_stall = 1'b1;
          cnt_d    = cnt_q + 8'd1;
          if (cnt_d == TMO) begin
            state_d = FAULT;
            clear   = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end else begin
          // Release from MEM_WAIT is an ordinary RUN cycle, so a redirect
          // held back by the freeze is taken here.
          cnt_d   = '0;
          advance = 1'b1;
          state_d = RUN;
          if (take_redirect) begin
            redirect = 1'b1;
            id_flush = 1'b1;
            bubble   = 1'b1;
          end else if (hazard) begin
            pc_stall = 1'b1;
            id_stall = 1'b1;
            bubble   = 1'b1;
`ifdef HAZARD_FWD_EN
            state_d  = LU_STALL;
`endif
          end
        end
      end
    endcase
  end

  // FSM state and dmem wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // EX and MEM slot advance; bubble squashes the ID instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v    <= 1'b0;
      ex_rd   <= '0;
      ex_cls  <= CL_NONE;
      mem_v   <= 1'b0;
      mem_rd  <= '0;
      mem_cls <= CL_NONE;
    end else if (clear) begin
      ex_v    <= 1'b0;
      mem_v   <= 1'b0;
    end else if (advance) begin
      mem_v   <= ex_v;
      mem_rd  <= ex_rd;
      mem_cls <= ex_cls;
      ex_v    <= id_valid && !bubble;
      ex_rd   <= id_rd;
      ex_cls  <= id_cls;
    end
  end

  assign ex_valid = ex_v;

endmodule
